// File: rtl/disaster_alert_ctrl.sv
// Four-hazard alert controller: raw hazard conditions are persistence-filtered
// and hysteresis-cleared per hazard, with per-hazard acknowledgeable pending
// flags driving the buzzer and a saturating count of alarm events.
module disaster_alert_ctrl #(
  parameter int unsigned W      = 2,
  parameter int unsigned TH_HI  = 3,
  parameter int unsigned TH_MID = 2,
  parameter int unsigned HOLD   = 4,
  parameter int unsigned CLEAR  = 8,
  parameter int unsigned EVT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     r,
  input  logic [W-1:0]     s,
  input  logic [W-1:0]     w,
  input  logic [W-1:0]     l,
  input  logic             mode,
  input  logic [3:0]       ack,
  output logic             flood_led,
  output logic             cyclone_led,
  output logic             earthquake_led,
  output logic             tsunami_led,
  output logic [3:0]       pending,
  output logic             buzzer,
  output logic [EVT_W-1:0] event_count
);

  localparam int unsigned MAXHC = (HOLD > CLEAR) ? HOLD : CLEAR;
  localparam int unsigned CW    = $clog2(MAXHC) + 1;
  localparam int unsigned SW    = EVT_W + 3;

  localparam logic [W-1:0]     HI         = W'(TH_HI);
  localparam logic [W-1:0]     MID        = W'(TH_MID);
  localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]    HOLD_LAST  = CW'(HOLD - 1);
  localparam logic [CW-1:0]    CLEAR_LAST = CW'(CLEAR - 1);
  localparam logic [EVT_W-1:0] EVT_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    ALARM    = 2'd2,
    CLEARING = 2'd3
  } state_e;

  logic [3:0]       cond;
  state_e           state_q [4];
  state_e           state_d [4];
  logic [CW-1:0]    cnt_q   [4];
  logic [CW-1:0]    cnt_d   [4];
  logic [3:0]       enter;
  logic [3:0]       led_q, led_d;
  logic [3:0]       pending_q, pending_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic [2:0]       n_enter;
  logic [SW-1:0]    evt_sum;

  // Raw hazard conditions from the current sensor levels, bit order {tsu,eq,cyc,flood}
  always_comb begin
    cond    = '0;
    cond[0] = (r >= HI) && (l >= MID);
    cond[1] = (w >= HI) && (r >= MID);
    cond[2] = (s >= HI);
    cond[3] = mode && (s >= MID) && (l >= HI);
  end

  // Per-hazard filter FSMs plus pending, LED and event-count next state
  always_comb begin
    n_enter = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      enter[i]   = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (cond[i]) begin
            cnt_d[i] = CNT_ONE;
            if (HOLD == 1) begin
              state_d[i] = ALARM;
              enter[i]   = 1'b1;
            end else begin
              state_d[i] = PENDING;
            end
          end
        end
        PENDING: begin
          if (!cond[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == HOLD_LAST) begin
            state_d[i] = ALARM;
            enter[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        ALARM: begin
          if (!cond[i]) begin
            cnt_d[i]   = CNT_ONE;
            state_d[i] = (CLEAR == 1) ? IDLE : CLEARING;
          end
        end
        CLEARING: begin
          if (cond[i]) begin
            state_d[i] = ALARM;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CLEAR_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      led_d[i]     = (state_d[i] == ALARM) || (state_d[i] == CLEARING);
      // A new alarm outranks an acknowledge on the same edge
      pending_d[i] = enter[i] | (pending_q[i] & ~ack[i]);
      n_enter      = n_enter + 3'(enter[i]);
    end
    evt_sum = SW'(evt_q) + SW'(n_enter);
    evt_d   = (evt_sum > SW'(EVT_MAX)) ? EVT_MAX : evt_sum[EVT_W-1:0];
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      led_q     <= '0;
      pending_q <= '0;
      evt_q     <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      led_q     <= led_d;
      pending_q <= pending_d;
      evt_q     <= evt_d;
    end
  end

  assign flood_led      = led_q[0];
  assign cyclone_led    = led_q[1];
  assign earthquake_led = led_q[2];
  assign tsunami_led    = led_q[3];
  assign pending        = pending_q;
  assign buzzer         = |pending_q;
  assign event_count    = evt_q;

endmodule

// File: doc/disaster_alert_ctrl.md
Name: disaster_alert_ctrl

Overview:
- Clocked successor to the combinational four-hazard warning decoder (flood, cyclone, earthquake, tsunami).
- Sensor width and thresholds are parameterised.
- Each hazard has persistence filtering and clear hysteresis, so one-sample glitches do not light LEDs.
- Adds an acknowledgeable buzzer and a saturating alarm-event counter. Sits between the sensor front end and the LED/buzzer driver.

Parameters:
W, 2, width of each sensor level input
TH_HI, 3, "high" threshold (level >= TH_HI); must be < 2**W
TH_MID, 2, "mid" threshold (level >= TH_MID); TH_MID <= TH_HI
HOLD, 4, consecutive true samples needed to raise an alarm (>= 1)
CLEAR, 8, consecutive false samples needed to drop an alarm (>= 1)
EVT_W, 8, width of event counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
r  input  W  rainfall level
s  input  W  seismic level
w  input  W  wind level
l  input  W  water level
mode  input  1  1 = coastal (tsunami enabled), 0 = inland (tsunami condition forced false)
ack  input  4  per-hazard acknowledge, bit order {tsunami,earthquake,cyclone,flood}
flood_led  output  1  flood alarm active
cyclone_led  output  1  cyclone alarm active
earthquake_led  output  1  earthquake alarm active
tsunami_led  output  1  tsunami alarm active
pending  output  4  unacknowledged new alarm per hazard, same bit order as ack
buzzer  output  1  OR of pending
event_count  output  EVT_W  count of IDLE/PENDING->ALARM transitions, saturating

Behaviour:
Raw conditions, combinational from current inputs, comparisons unsigned:
- flood: r>=TH_HI && l>=TH_MID
- cyclone: w>=TH_HI && r>=TH_MID
- earthquake: s>=TH_HI
- tsunami: mode && s>=TH_MID && l>=TH_HI

Per-hazard FSM, four independent instances:
- States IDLE, PENDING, ALARM, CLEARING. Each instance has a counter of width clog2(max(HOLD,CLEAR))+1.
- IDLE: c=1 -> cnt=1; go to ALARM if HOLD==1, else PENDING.
- PENDING: c=0 -> IDLE, cnt=0. c=1 and cnt==HOLD-1 -> ALARM. Otherwise cnt++.
- ALARM: c=0 -> cnt=1; go to IDLE if CLEAR==1, else CLEARING. c=1 -> stay.
- CLEARING: c=1 -> ALARM, cnt=0 (no new event, pending not re-set). c=0 and cnt==CLEAR-1 -> IDLE. Otherwise cnt++.

LEDs:
- *_led is registered: high in ALARM or CLEARING, low in IDLE or PENDING.
- Condition first true at edge k and held -> led high after edge k+HOLD-1.
- Condition first false at edge m and held -> led low after edge m+CLEAR-1.

Pending, buzzer and events:
- pending[i] is set on the edge that enters ALARM from IDLE or PENDING.
- ack[i]=1 at an edge clears pending[i]. Set and ack on the same edge -> set wins.
- ack on a hazard that is not pending has no effect.
- buzzer is combinational OR of the registered pending bits.
- event_count increments by the number of hazards entering ALARM from IDLE/PENDING on that edge (0..4). It saturates at 2**EVT_W-1 and never wraps.

Mode and reset:
- mode 1->0 while tsunami is in ALARM -> tsunami enters CLEARING. This is normal hysteresis, no immediate drop.
- rst_n low, asynchronous at any time, including mid-PENDING or CLEARING: all FSMs IDLE, counters 0, all LEDs 0, pending 0, buzzer 0, event_count 0.
- Reset release is synchronous-safe: first evaluation at the first rising edge with rst_n high.

Test Plan:
1. Defaults, mode=0, s=3 held 4 edges -> earthquake_led=1, pending=4'b0100, buzzer=1 after 4th edge, event_count=1. s=3 held only 3 edges then s=0 -> led stays 0, event_count stays 0.
2. Earthquake in ALARM, s=0 for 7 edges -> earthquake_led still 1. s=3 on 8th edge -> remains ALARM, event_count unchanged. Then s=0 for 8 edges -> led 0 after 8th.
3. ack=4'b0100 pulsed one edge with earthquake alarm -> pending=0, buzzer=0, earthquake_led still 1. Ack coincident with flood entering ALARM: ack=4'b0001 -> pending[0]=1.
4. mode=1, s=2, l=3 for 4 edges -> tsunami_led=1. mode->0 -> tsunami_led stays 1 for 7 more edges, drops after 8th.
5. r=3, w=3, l=2, s=3, mode=1 all held 4 edges -> flood, cyclone, earthquake LEDs rise on the same edge, event_count +3. Tsunami needs l=3 and stays 0.
6. EVT_W=2: generate 5 alarm events -> event_count saturates at 3. Assert rst_n=0 asynchronously mid-PENDING -> all outputs 0 without waiting for a clock edge.
